// File: rtl/ps2_scancode_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames, checks parity/stop, drops
// break (F0) and extended (E0) sequences, and emits plain make codes.
module ps2_scancode_rx #(
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       ps2_clk,
  input  logic       ps2_dat,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err,
  output logic [1:0] dbg_state_o
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_e;

  localparam int unsigned TW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYCLES - 1);

  logic clk_s1_q, clk_s2_q, clk_prev_q;
  logic dat_s1_q, dat_s2_q;

  state_e        state_q, state_d;
  logic [2:0]    bit_cnt_q, bit_cnt_d;
  logic [7:0]    byte_q, byte_d;
  logic          par_q, par_d;
  logic          brk_q, brk_d;
  logic          ext_q, ext_d;
  logic [7:0]    scan_q, scan_d;
  logic          valid_q, valid_d;
  logic          err_q, err_d;
  logic [TW-1:0] tmo_q, tmo_d;

  logic fall;
  logic tmo_fire;

  // Synchronizers reset to the idle bus level so reset release never fakes an edge.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      clk_s1_q   <= 1'b1;
      clk_s2_q   <= 1'b1;
      clk_prev_q <= 1'b1;
      dat_s1_q   <= 1'b1;
      dat_s2_q   <= 1'b1;
    end else begin
      clk_s1_q   <= ps2_clk;
      clk_s2_q   <= clk_s1_q;
      clk_prev_q <= clk_s2_q;
      dat_s1_q   <= ps2_dat;
      dat_s2_q   <= dat_s1_q;
    end
  end

  assign fall     = clk_prev_q & ~clk_s2_q;
  assign tmo_fire = (state_q != S_IDLE) && (tmo_q == TMO_LAST);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q   <= S_IDLE;
      bit_cnt_q <= 3'd0;
      byte_q    <= 8'h00;
      par_q     <= 1'b0;
      brk_q     <= 1'b0;
      ext_q     <= 1'b0;
      scan_q    <= 8'h00;
      valid_q   <= 1'b0;
      err_q     <= 1'b0;
      tmo_q     <= '0;
    end else begin
      state_q   <= state_d;
      bit_cnt_q <= bit_cnt_d;
      byte_q    <= byte_d;
      par_q     <= par_d;
      brk_q     <= brk_d;
      ext_q     <= ext_d;
      scan_q    <= scan_d;
      valid_q   <= valid_d;
      err_q     <= err_d;
      tmo_q     <= tmo_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    bit_cnt_d = bit_cnt_q;
    byte_d    = byte_q;
    par_d     = par_q;
    brk_d     = brk_q;
    ext_d     = ext_q;
    scan_d    = scan_q;
    valid_d   = 1'b0;
    err_d     = 1'b0;
    tmo_d     = (state_q == S_IDLE || fall) ? '0 : tmo_q + TW'(1);

    // A timeout pre-empts any edge detected in the same cycle.
    if (tmo_fire) begin
      state_d   = S_IDLE;
      bit_cnt_d = 3'd0;
      brk_d     = 1'b0;
      ext_d     = 1'b0;
      err_d     = 1'b1;
      tmo_d     = '0;
    end else if (fall) begin
      case (state_q)
        S_IDLE: begin
          if (!dat_s2_q) begin
            state_d   = S_DATA;
            bit_cnt_d = 3'd0;
          end
        end
        S_DATA: begin
          byte_d[bit_cnt_q] = dat_s2_q;
          bit_cnt_d         = bit_cnt_q + 3'd1;
          if (bit_cnt_q == 3'd7) state_d = S_PARITY;
        end
        S_PARITY: begin
          par_d   = dat_s2_q;
          state_d = S_STOP;
        end
        S_STOP: begin
          state_d = S_IDLE;
          if (dat_s2_q && (^{byte_q, par_q})) begin
            if (byte_q == 8'hF0) begin
              brk_d = 1'b1;
            end else if (byte_q == 8'hE0) begin
              ext_d = 1'b1;
            end else if (brk_q || ext_q) begin
              brk_d = 1'b0;
              ext_d = 1'b0;
            end else begin
              scan_d  = byte_q;
              valid_d = 1'b1;
            end
          end else begin
            err_d = 1'b1;
            brk_d = 1'b0;
            ext_d = 1'b0;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign scan_code   = scan_q;
  assign code_valid  = valid_q;
  assign frame_err   = err_q;
  assign dbg_state_o = state_q;

endmodule

// File: doc/ps2_scancode_rx.md
# ps2_scancode_rx

Receives the serial PS/2 keyboard stream, deframes 11-bit frames, checks odd parity and stop bit, and strips break (0xF0) and extended (0xE0) sequences so that only plain make codes reach the letter decoder downstream. Sits between the keyboard pins and the scan-code-to-letter decoder; its `scan_code` output drives the decoder's `inCode` input directly, qualified by `code_valid`.

## Interface
- `TIMEOUT_CYCLES`, default 50000: idle `clk` cycles allowed between PS/2 falling edges inside a frame before the frame is abandoned (1 ms at 50 MHz).
- `clk` in 1: system clock, one clock domain; all logic on the rising edge.
- `resetn` in 1: asynchronous, active-low reset.
- `ps2_clk` in 1: raw PS/2 clock pin, asynchronous to `clk`.
- `ps2_dat` in 1: raw PS/2 data pin, asynchronous to `clk`.
- `scan_code` out 8: last accepted make code; holds its value until the next accepted code.
- `code_valid` out 1: one-cycle pulse when `scan_code` is updated.
- `frame_err` out 1: one-cycle pulse on a parity error, stop-bit error or timeout.

## Operation
- Both pins pass through 2-flop synchronizers, then a registered previous value of synchronized `ps2_clk`. A falling edge is detected when the previous value is 1 and the current value is 0; `ps2_dat` (synchronized) is sampled in that cycle.
- Frame format: start bit 0, D0..D7 LSB first, odd parity bit (ones in D0..D7 plus parity is odd), stop bit 1.
- The FSM advances only on detected falling edges:
  - IDLE -> DATA if the sampled bit is 0. A start bit of 1 is ignored: stay in IDLE with no error.
  - DATA: shift the sample into the byte register at bit position `bit_cnt` (3-bit counter, 0..7). After the eighth bit, go to PARITY.
  - PARITY: store the parity bit, then go to STOP.
  - STOP: the frame is good if the stop bit is 1 and parity is odd. Either failure pulses `frame_err` and returns to IDLE. A good frame goes to IDLE and passes the byte to the prefix filter.
- Prefix filter, with registered flags `brk` and `ext`:
  - byte 0xF0: set `brk`, no output.
  - byte 0xE0: set `ext`, no output.
  - any other byte with `brk` or `ext` set: discard it and clear both flags.
  - any other byte with both flags clear: load `scan_code` and pulse `code_valid`.
- Typematic repeats are emitted each time they arrive; no repeat suppression.
- Timeout: a counter runs while the FSM is not in IDLE and clears on every detected falling edge. When it reaches `TIMEOUT_CYCLES-1`: return to IDLE, clear `bit_cnt`, clear `brk`/`ext`, and pulse `frame_err`.
- Any `frame_err` also clears `brk` and `ext`.
- Reset values: FSM IDLE, `scan_code` 0x00, `code_valid` 0, `frame_err` 0, `brk`/`ext` 0, all counters 0, synchronizer flops 1 (idle bus level).

## Timing
- Pin to detection: a pin change is visible in the edge detector 2–3 `clk` cycles after it occurs.
- If the stop-bit falling edge is detected in cycle N, `code_valid` or `frame_err` is high in cycle N+1 only. `scan_code` is stable from N+1 onward.
- At most one output pulse per frame; `code_valid` and `frame_err` are never high together.
- An edge detected in the same cycle the timeout fires: the timeout wins and the edge is discarded.
- `resetn` low mid-frame: immediate asynchronous return to reset values. After release, reception resumes at the next start bit. A frame in flight when reset is released decodes as garbage and is caught by the parity, stop-bit or timeout checks.
- Supported PS/2 clock: 10–16.7 kHz. `clk` must be at least 1 MHz so each PS/2 clock phase spans 3 or more `clk` cycles.

## Test plan
- Frame 0x1C (parity 0, stop 1) at a 12.5 kHz bit rate: exactly one `code_valid` pulse, `scan_code`=0x1C, `frame_err` stays 0.
- Frames F0, 1C: no `code_valid` pulse. A following 0x32 frame gives `scan_code`=0x32 with one pulse.
- Frames E0, 75, then 0x5A: only 0x5A is emitted.
- Frame 0x1C with parity bit 1: one `frame_err` pulse, no `code_valid`, `scan_code` keeps its prior value.
- Start bit plus 5 data bits, then `ps2_clk` held high (`TIMEOUT_CYCLES`=100): `frame_err` pulses in the 100th idle cycle. A following full 0x32 frame is received correctly.
- F0 sent, then `resetn` pulsed low mid-way through the next frame, then a clean 0x24 frame: 0x24 is emitted because `brk` was cleared by reset. All outputs read 0 during reset.
